// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin front end that shares one combinational FADD
// datapath among NREQ requesters. Winning operands are registered onto the
// FADD inputs and held for EXEC_CYCLES clocks (multicycle path). The result
// is then captured and returned with the requester id over a valid/ready
// response channel.
module fadd_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int EXEC_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic [NREQ-1:0]    i_req_mode,
    input  logic [64*NREQ-1:0] i_req_a,
    input  logic [64*NREQ-1:0] i_req_b,
    output logic               o_fadd_mode,
    output logic [63:0]        o_fadd_a,
    output logic [63:0]        o_fadd_b,
    input  logic [63:0]        i_fadd_res,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [IDW-1:0]     o_rsp_id,
    output logic               o_rsp_mode,
    output logic [63:0]        o_rsp_res,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [3:0]          r_cnt;
    logic                r_fadd_mode;
    logic [63:0]         r_fadd_a;
    logic [63:0]         r_fadd_b;
    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic                r_rsp_mode;
    logic [63:0]         r_rsp_res;
    logic                r_busy;

    logic                w_any;
    logic [IDW-1:0]      w_gidx;
    logic [NREQ-1:0]     w_ready;
    logic [2*NREQ-1:0]   w_rot;
    logic [IDW:0]        w_sum;

    // Round-robin search: rotate the request vector so bit 0 is the pointer
    // position, then take the first set bit and map it back to a port index.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_sum  = '0;
        w_rot  = {i_req_valid, i_req_valid} >> r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && w_rot[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
                if (w_sum >= (IDW+1)'(NREQ)) begin
                    w_gidx = IDW'(w_sum - (IDW+1)'(NREQ));
                end else begin
                    w_gidx = IDW'(w_sum);
                end
            end else begin
                w_any  = w_any;
                w_gidx = w_gidx;
            end
        end
    end

    // Accept strobe: one-hot on the winner, only while idle and out of reset.
    always_comb begin
        w_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (i_rst_n && (r_state == ST_IDLE) && w_any && (w_gidx == IDW'(k))) begin
                w_ready[k] = 1'b1;
            end else begin
                w_ready[k] = 1'b0;
            end
        end
    end

    // Control FSM with registered FADD operands and response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= 4'd0;
            r_fadd_mode <= 1'b0;
            r_fadd_a    <= 64'd0;
            r_fadd_b    <= 64'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_mode  <= 1'b0;
            r_rsp_res   <= 64'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        // Operands are sampled only here; later input changes
                        // cannot disturb the op in flight.
                        r_fadd_mode <= i_req_mode[w_gidx];
                        r_fadd_a    <= i_req_a[64*int'(w_gidx) +: 64];
                        r_fadd_b    <= i_req_b[64*int'(w_gidx) +: 64];
                        r_id        <= w_gidx;
                        if (w_gidx == IDW'(NREQ-1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_gidx + IDW'(1);
                        end
                        r_cnt   <= 4'(EXEC_CYCLES-1);
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_res   <= i_fadd_res;
                        r_rsp_mode  <= r_fadd_mode;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cnt       <= 4'd0;
                end
            endcase
        end
    end

    assign o_req_ready = w_ready;
    assign o_fadd_mode = r_fadd_mode;
    assign o_fadd_a    = r_fadd_a;
    assign o_fadd_b    = r_fadd_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_mode  = r_rsp_mode;
    assign o_rsp_res   = r_rsp_res;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a transaction-level
// reference model. A behavioural FADD drives i_fadd_res.
module tb_fadd_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int EC   = 2;

    logic               i_clk;
    logic               i_rst_n;
    logic [NREQ-1:0]    i_req_valid;
    logic [NREQ-1:0]    o_req_ready;
    logic [NREQ-1:0]    i_req_mode;
    logic [64*NREQ-1:0] i_req_a;
    logic [64*NREQ-1:0] i_req_b;
    logic               o_fadd_mode;
    logic [63:0]        o_fadd_a;
    logic [63:0]        o_fadd_b;
    logic [63:0]        i_fadd_res;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [IDW-1:0]     o_rsp_id;
    logic               o_rsp_mode;
    logic [63:0]        o_rsp_res;
    logic               o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    fadd_arbiter #(.NREQ(NREQ), .IDW(IDW), .EXEC_CYCLES(EC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_mode(i_req_mode), .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_fadd_mode(o_fadd_mode), .o_fadd_a(o_fadd_a), .o_fadd_b(o_fadd_b),
        .i_fadd_res(i_fadd_res),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_id(o_rsp_id), .o_rsp_mode(o_rsp_mode), .o_rsp_res(o_rsp_res),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- floating-point helpers ----------------
    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        e = d[62:52];
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        e = 11'(s[30:23]) + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [63:0] fp_add(input logic mode, input logic [63:0] a, input logic [63:0] b);
        if (mode) return $realtobits($bitstoreal(a) + $bitstoreal(b));
        return {d2s($realtobits($bitstoreal(s2d(a[63:32])) + $bitstoreal(s2d(b[63:32])))),
                d2s($realtobits($bitstoreal(s2d(a[31:0]))  + $bitstoreal(s2d(b[31:0]))))};
    endfunction

    function automatic logic [63:0] dbl(input int v);
        return $realtobits(real'(v));
    endfunction

    function automatic logic [31:0] sgl(input int v);
        return d2s($realtobits(real'(v)));
    endfunction

    function automatic logic [63:0] rand_op(input logic mode);
        if (mode) return dbl(int'($urandom_range(1, 1000)));
        return {sgl(int'($urandom_range(1, 1000))), sgl(int'($urandom_range(1, 1000)))};
    endfunction

    // Behavioural FADD instance fed by the registered operands.
    always_comb i_fadd_res = fp_add(o_fadd_mode, o_fadd_a, o_fadd_b);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_ptr;
    bit          m_inflight;
    int          m_cyc;
    int          m_rsp_cyc;
    int          m_id;
    logic        m_mode;
    logic [63:0] m_a, m_b, m_res;
    int          grants[$];

    task automatic model_reset();
        m_ptr = 0; m_inflight = 0; m_cyc = 0; m_rsp_cyc = 0;
    endtask

    task automatic model_step();
        int g;
        bit found;
        bit rv;
        logic [NREQ-1:0] er;
        found = 0; g = 0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (!found && i_req_valid[k]) begin found = 1; g = k; end
        end
        er = '0;
        if (!m_inflight && found) er[g] = 1'b1;
        chk("req_ready", o_req_ready, er);
        rv = m_inflight && (m_cyc >= m_rsp_cyc);
        chk("rsp_valid", o_rsp_valid, rv);
        chk("busy", o_busy, m_inflight);
        if (m_inflight) begin
            chk("fadd_mode", o_fadd_mode, m_mode);
            chk("fadd_a", o_fadd_a, m_a);
            chk("fadd_b", o_fadd_b, m_b);
        end
        if (rv) begin
            chk("rsp_id", o_rsp_id, m_id);
            chk("rsp_mode", o_rsp_mode, m_mode);
            chk("rsp_res", o_rsp_res, m_res);
        end
        if (rv && i_rsp_ready) begin
            m_inflight = 0;
        end else if (!m_inflight && found) begin
            m_id       = g;
            m_mode     = i_req_mode[g];
            m_a        = i_req_a[64*g +: 64];
            m_b        = i_req_b[64*g +: 64];
            m_res      = fp_add(m_mode, m_a, m_b);
            m_inflight = 1;
            m_rsp_cyc  = m_cyc + EC + 1;
            m_ptr      = (g + 1) % NREQ;
        end
        m_cyc++;
    endtask

    // One clock: sample after inputs settle, check, advance to next negedge.
    task automatic tick();
        #1;
        for (int k = 0; k < NREQ; k++) if (o_req_ready[k]) grants.push_back(k);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic set_req(input int k, input logic mode, input logic [63:0] a, input logic [63:0] b);
        i_req_mode[k]      = mode;
        i_req_a[64*k +: 64] = a;
        i_req_b[64*k +: 64] = b;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!o_rsp_valid && n < 40) begin tick(); n++; end
        if (!o_rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        i_req_valid = '0;
        i_rsp_ready = 1'b1;
        n = 0;
        while (m_inflight && n < 50) begin tick(); n++; end
        if (m_inflight) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        logic [IDW-1:0] s_id;
        logic           s_mode;
        logic [63:0]    s_res;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        i_clk = 1'b0; i_rst_n = 1'b0; i_req_valid = '0; i_req_mode = '0;
        i_req_a = '0; i_req_b = '0; i_rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);

        // reset state
        chk("rst_rsp_valid", o_rsp_valid, 64'd0);
        chk("rst_busy", o_busy, 64'd0);
        chk("rst_req_ready", o_req_ready, 64'd0);
        chk("rst_fadd_a", o_fadd_a, 64'd0);
        chk("rst_fadd_b", o_fadd_b, 64'd0);
        chk("rst_fadd_mode", o_fadd_mode, 64'd0);
        chk("rst_rsp_res", o_rsp_res, 64'd0);
        chk("rst_rsp_id", o_rsp_id, 64'd0);
        chk("rst_rsp_mode", o_rsp_mode, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // single double op
        set_req(0, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000);
        i_req_valid = 4'b0001; i_rsp_ready = 1'b1;
        #1 chk("t1_ready", o_req_ready, 64'h1);
        tick();
        i_req_valid = '0;
        wait_rsp(n);
        chk("t1_latency", n, EC);
        chk("t1_id", o_rsp_id, 64'd0);
        chk("t1_mode", o_rsp_mode, 64'd1);
        chk("t1_res", o_rsp_res, 64'h4008000000000000);
        tick();

        // dual packed single op
        set_req(2, 1'b0, 64'h3F80000040000000, 64'h400000003F800000);
        i_req_valid = 4'b0100;
        tick();
        i_req_valid = '0;
        wait_rsp(n);
        chk("t2_id", o_rsp_id, 64'd2);
        chk("t2_mode", o_rsp_mode, 64'd0);
        chk("t2_res", o_rsp_res, 64'h4040000040400000);
        tick();

        // operand isolation
        set_req(1, 1'b1, dbl(5), dbl(7));
        i_req_valid = 4'b0010;
        tick();
        i_req_valid = '0;
        i_req_a[64 +: 64] = dbl(100);
        tick();
        chk("iso_fadd_a", o_fadd_a, dbl(5));
        wait_rsp(n);
        chk("iso_res", o_rsp_res, dbl(12));
        tick();

        // backpressure
        set_req(3, 1'b1, dbl(40), dbl(2));
        i_req_valid = 4'b1000;
        tick();
        i_req_valid = '0;
        wait_rsp(n);
        i_rsp_ready = 1'b0;
        i_req_valid = 4'hF;
        s_id = o_rsp_id; s_mode = o_rsp_mode; s_res = o_rsp_res;
        chk("bp_res", s_res, dbl(42));
        repeat (10) begin
            tick();
            chk("bp_ready_low", o_req_ready, 64'd0);
            chk("bp_id_stable", o_rsp_id, s_id);
            chk("bp_mode_stable", o_rsp_mode, s_mode);
            chk("bp_res_stable", o_rsp_res, s_res);
        end
        i_rsp_ready = 1'b1;
        #1 chk("bp_hs_ready", o_req_ready, 64'd0);
        tick();
        #1 chk("bp_regrant", o_req_ready, 64'h1);
        tick();
        drain();

        // reset mid-EXEC, then round-robin from a clean pointer
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, rand_op(1'b1), rand_op(1'b1));
        i_req_valid = 4'hF;
        tick();
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", o_rsp_valid, 64'd0);
        chk("mid_rst_busy", o_busy, 64'd0);
        chk("mid_rst_fadd_a", o_fadd_a, 64'd0);
        chk("mid_rst_fadd_b", o_fadd_b, 64'd0);
        chk("mid_rst_fadd_mode", o_fadd_mode, 64'd0);
        chk("mid_rst_ready", o_req_ready, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        grants.delete();
        repeat ((EC + 2) * 5) tick();
        if (grants.size() < 5) chk("rr_count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], exp_order[i]);
        drain();

        // randomized traffic
        repeat (800) begin
            for (int k = 0; k < NREQ; k++) begin
                logic md;
                md = 1'($urandom_range(0, 1));
                i_req_valid[k] = ($urandom_range(0, 99) < 55);
                set_req(k, md, rand_op(md), rand_op(md));
            end
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
- Shares one combinational FADD datapath among NREQ independent requesters.
- Each requester presents a mode and two 64-bit operands with a valid/ready handshake.
- The block arbitrates round-robin, registers the winning operands onto the FADD inputs, and waits EXEC_CYCLES for the FADD path to settle (multicycle path).
- It then captures the result and returns it, tagged with the requester id, over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal ceil(log2(NREQ)), minimum 1.
- EXEC_CYCLES, 2, cycles from operand-register load to result capture (1..15).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NREQ  per-requester request valid.
- o_req_ready  output  NREQ  per-requester accept strobe; one-hot or zero.
- i_req_mode  input  NREQ  per-requester mode: 1 = double, 0 = dual packed single.
- i_req_a  input  64*NREQ  operand A, requester k at bits [64k+63:64k].
- i_req_b  input  64*NREQ  operand B, same packing.
- o_fadd_mode  output  1  registered mode to FADD.
- o_fadd_a  output  64  registered operand A to FADD.
- o_fadd_b  output  64  registered operand B to FADD.
- i_fadd_res  input  64  FADD result.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_id  output  IDW  id of requester owning the response.
- o_rsp_mode  output  1  mode of the completed operation.
- o_rsp_res  output  64  captured result.
- o_busy  output  1  high in EXEC or RESP.

Behaviour:
- Clock and reset: single clock i_clk. i_rst_n is asynchronous assert, synchronous deassert (externally synchronised).
- Reset values:
  - State = IDLE; rr pointer = 0; exec counter = 0.
  - o_fadd_mode/a/b = 0; o_rsp_res = 0; o_rsp_id = 0; o_rsp_mode = 0.
  - o_rsp_valid = 0; o_busy = 0; o_req_ready = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready is combinational. It is one-hot on the grant g only when state = IDLE and some i_req_valid = 1.
  - g = first k with i_req_valid[k] = 1, searching from index ptr upward with wrap modulo NREQ.
  - Handshake completes in the same cycle as valid & ready.
  - On that edge: o_fadd_* <= requester g operands and mode; id register <= g; ptr <= (g+1) mod NREQ; counter <= EXEC_CYCLES-1; go to EXEC.
  - No valid requests: stay in IDLE; ptr is unchanged.
- EXEC:
  - o_fadd_* are held stable. Counter decrements each cycle.
  - When counter = 0: o_rsp_res <= i_fadd_res, o_rsp_mode <= o_fadd_mode, o_rsp_id <= id register; go to RESP.
  - Load-to-capture latency is EXEC_CYCLES clocks.
- RESP:
  - o_rsp_valid = 1; o_rsp_* held stable until i_rsp_ready = 1.
  - On a handshake: go to IDLE. A new grant happens at the earliest on the following cycle.
  - Minimum issue interval is EXEC_CYCLES+2 cycles.
- o_req_ready is 0 in EXEC and RESP, whatever i_req_valid is.
- A requester may deassert valid before it is granted; there is no penalty and no state change.
- Operands are sampled only on the grant edge. Later input changes do not affect an in-flight op.
- Fairness: a continuously requesting port waits at most NREQ-1 other operations.
- Simultaneous events:
  - All requesters valid at once: grant the port at ptr.
  - A response handshake and a new request arriving in the same cycle: the request waits one cycle (granted from IDLE).
- Reset mid-operation: the in-flight op is discarded with no response, and all outputs return to reset values asynchronously.
- The block performs no arithmetic on operands. All results come from the FADD instance.

Test Plan:
- Single double op: after reset, requester 0 drives mode = 1, A = 0x3FF0000000000000, B = 0x4000000000000000. Required: o_req_ready[0] = 1 in the request cycle; o_rsp_valid rises EXEC_CYCLES+1 cycles after grant; o_rsp_id = 0, o_rsp_mode = 1, o_rsp_res = 0x4008000000000000.
- Dual-single op: requester 2 drives mode = 0, A = 0x3F80000040000000, B = 0x400000003F800000. Required: o_rsp_id = 2, o_rsp_res = 0x4040000040400000.
- Round-robin: all 4 requesters hold valid, i_rsp_ready = 1. Required: grant order 0,1,2,3,0; each port's result matches its own operands; no port is granted twice before all others.
- Backpressure: i_rsp_ready = 0 for 10 cycles during RESP. Required: o_rsp_* stable; o_req_ready = 0 throughout; no new grant until 1 cycle after the response handshake.
- Operand isolation: requester 1 changes A one cycle after its grant. Required: o_fadd_a and the result reflect the originally granted A.
- Reset mid-EXEC: deassert i_rst_n during EXEC. Required: o_rsp_valid = 0, o_busy = 0, o_fadd_* = 0 immediately; after release, the first grant goes to requester 0 when all requesters are valid.
